sseg_scanner: RTL and testbench
===============================

# sseg_scanner

Four-digit seven-segment scanner that sits directly downstream of the BCD/hex decade counter chain. It takes the four counter nibbles (ones through thousands), time-multiplexes them onto the shared active-low segment bus and anode lines, and adds frame-synchronous capture, leading-zero blanking, per-digit decimal points and 8-level PWM brightness. It replaces ad-hoc anode/selector logic in the top level with a single registered, glitch-free display driver.

## Interface
- DIGIT_CYCLES, 16384, clk cycles each digit slot is active; must be a multiple of 8 and at least 8.
- clk  in  1  system clock (100 MHz on board).
- reset_n  in  1  asynchronous, active-low reset.
- digits  in  16  display value; [3:0] = digit 0 (ones, rightmost) … [15:12] = digit 3 (thousands).
- dp  in  4  decimal point request per digit, 1 = lit; bit i pairs with digit i.
- blank_lz  in  1  1 = blank leading zeros in digits 3..1.
- brightness  in  3  0 = dimmest (1/8 duty), 7 = full (8/8 duty).
- sseg  out  7  segments, active-low; [0]=a … [6]=g.
- dp_n  out  1  decimal point, active-low.
- AN  out  8  anodes, active-low; AN[i] drives digit i; AN[7:4] always 1.
- frame_tick  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- Slot counter cnt: 0..DIGIT_CYCLES-1. Digit selector sel: 0..3; advances when cnt wraps; 3 wraps to 0. One frame = 4*DIGIT_CYCLES cycles.
- Shadow registers (digits, dp, blank_lz, brightness) load on the last cycle of a frame (sel=3, cnt=DIGIT_CYCLES-1). Mid-frame input changes are invisible until the next frame. Reset clears all shadows to 0.
- Decode: full hex 0–F on the selected shadow nibble (0→7'b1000000, 1→7'b1111001, 8→7'b0000000, F→7'b0001110; bit order g..a).
- Leading-zero blanking: digit i (i = 1..3) is blank when shadow blank_lz=1 and shadow digits i..3 are all zero. Digit 0 is never blanked. Blank digit: AN[i]=1, sseg=7'h7F, dp_n=1, and its dp request is ignored.
- PWM: phase = cnt / (DIGIT_CYCLES/8), range 0..7. The digit is lit when phase <= shadow brightness. When unlit: AN=8'hFF, sseg=7'h7F, dp_n=1.
- Lit digit: AN = 8'hFF with bit sel cleared; sseg = decode; dp_n = ~shadow dp[sel].
- Exactly one AN bit may be low at any time. Never more than one.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect cnt, sel and shadows as they stand in cycle t.
- Reset (reset_n low, asynchronous): cnt=0, sel=0, shadows=0, AN=8'hFF, sseg=7'h7F, dp_n=1, frame_tick=0.
- First cycle after reset release: outputs still hold reset values. From the second cycle, digit 0 shows "0" (shadow is 0) until the first shadow load.
- Shadow load latency: values present at a frame's last cycle are displayed from the first output cycle of the next frame. That is the cycle after the load, plus one for output registration.
- frame_tick is high for exactly one cycle, the cycle after each shadow load. Period is exactly 4*DIGIT_CYCLES. No tick occurs before the first load.
- Digit-to-digit transitions: AN changes in a single clock edge. There are no intermediate multi-anode states.
- Reset asserted mid-frame: all outputs go dark immediately (asynchronously). Scanning restarts from sel=0, cnt=0.

## Test plan
- DIGIT_CYCLES=16, reset released, digits=16'h1234, dp=0, blank_lz=0, brightness=7 -> after first frame_tick, AN cycles FE/FD/FB/F7 every 16 cycles showing 4,3,2,1; frame_tick period 64.
- digits=16'h0050, blank_lz=1 -> digit 0 "0", digit 1 "5", digits 2,3 have AN high and sseg=7'h7F. digits=16'h0000 -> only digit 0 lit, showing "0".
- brightness=0 -> each slot has 2 lit cycles then 14 dark (AN=FF). brightness=3 -> 8 lit, 8 dark. brightness=7 -> 16 lit.
- Change digits from 16'h1111 to 16'h2222 while sel=1 -> remainder of the frame still shows 1. The next frame shows 2 on all digits, starting with the first cycle after the tick-aligned update.
- dp=4'b0100, digits=16'h0123, blank_lz=1 -> dp_n=0 only during the digit-2 lit phase. With digits=16'h0003, the dp is not lit because digit 2 is blanked.
- Assert reset_n low mid-slot on sel=2 -> AN=FF, sseg=7F, dp_n=1 without waiting for a clock edge. After release, the scan restarts at digit 0 showing "0".

Source files
------------

// File: rtl/sseg_scanner.sv
// sseg_scanner: four-digit multiplexed seven-segment driver.
// Captures the counter nibbles once per frame, scans them onto the shared
// active-low segment bus with leading-zero blanking, per-digit decimal
// points and 8-level PWM brightness. All outputs leave from flops.
module sseg_scanner #(
   parameter int DIGIT_CYCLES = 16384
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] digits,
   input  logic [3:0]  dp,
   input  logic        blank_lz,
   input  logic [2:0]  brightness,
   output logic [6:0]  sseg,
   output logic        dp_n,
   output logic [7:0]  AN,
   output logic        frame_tick
);

   localparam int CW = (DIGIT_CYCLES > 8) ? $clog2(DIGIT_CYCLES) : 3;
   localparam int PHASE_DIV = DIGIT_CYCLES / 8;
   localparam logic [CW-1:0] CNT_LAST    = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] PHASE_DIV_W = CW'(PHASE_DIV);

   logic [CW-1:0] cnt;
   logic [1:0]    sel;
   logic          frame_end;

   logic [15:0]   sh_digits;
   logic [3:0]    sh_dp;
   logic          sh_blank_lz;
   logic [2:0]    sh_brightness;

   logic [CW-1:0] phase;
   logic [3:0]    nib;
   logic [3:0]    nib_zero;
   logic          blank;
   logic          lit;
   logic [7:0]    an_next;
   logic [6:0]    sseg_next;
   logic          dp_n_next;

   // Full hex decode, active-low, bit order g..a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_to_seg = 7'b1000000;
         4'h1: hex_to_seg = 7'b1111001;
         4'h2: hex_to_seg = 7'b0100100;
         4'h3: hex_to_seg = 7'b0110000;
         4'h4: hex_to_seg = 7'b0011001;
         4'h5: hex_to_seg = 7'b0010010;
         4'h6: hex_to_seg = 7'b0000010;
         4'h7: hex_to_seg = 7'b1111000;
         4'h8: hex_to_seg = 7'b0000000;
         4'h9: hex_to_seg = 7'b0010000;
         4'hA: hex_to_seg = 7'b0001000;
         4'hB: hex_to_seg = 7'b0000011;
         4'hC: hex_to_seg = 7'b1000110;
         4'hD: hex_to_seg = 7'b0100001;
         4'hE: hex_to_seg = 7'b0000110;
         default: hex_to_seg = 7'b0001110;
      endcase
   endfunction

   assign frame_end = (sel == 2'd3) && (cnt == CNT_LAST);

   // Slot counter and digit selector; selector steps when the slot wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         sel <= 2'd0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         sel <= sel + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Shadow capture on the last cycle of a frame so a frame never tears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_digits     <= 16'h0000;
         sh_dp         <= 4'h0;
         sh_blank_lz   <= 1'b0;
         sh_brightness <= 3'd0;
      end else if (frame_end) begin
         sh_digits     <= digits;
         sh_dp         <= dp;
         sh_blank_lz   <= blank_lz;
         sh_brightness <= brightness;
      end
   end

   // Select the active nibble and decide blanking / PWM for this cycle.
   always_comb begin
      phase = cnt / PHASE_DIV_W;
      for (int i = 0; i < 4; i++) begin
         nib_zero[i] = (sh_digits[4*i +: 4] == 4'h0);
      end
      nib   = sh_digits[3:0];
      blank = 1'b0;
      case (sel)
         2'd0: begin
            nib   = sh_digits[3:0];
            blank = 1'b0;
         end
         2'd1: begin
            nib   = sh_digits[7:4];
            blank = sh_blank_lz & nib_zero[1] & nib_zero[2] & nib_zero[3];
         end
         2'd2: begin
            nib   = sh_digits[11:8];
            blank = sh_blank_lz & nib_zero[2] & nib_zero[3];
         end
         default: begin
            nib   = sh_digits[15:12];
            blank = sh_blank_lz & nib_zero[3];
         end
      endcase
      lit = !blank && (phase <= CW'(sh_brightness));
      an_next   = 8'hFF;
      sseg_next = 7'h7F;
      dp_n_next = 1'b1;
      if (lit) begin
         an_next   = ~(8'h01 << sel);
         sseg_next = hex_to_seg(nib);
         dp_n_next = ~sh_dp[sel];
      end
   end

   // Output registers: a single edge moves the anode, so no multi-anode glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         AN         <= 8'hFF;
         sseg       <= 7'h7F;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         AN         <= an_next;
         sseg       <= sseg_next;
         dp_n       <= dp_n_next;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_sseg_scanner.sv
// tb_sseg_scanner: directed bench for sseg_scanner with DIGIT_CYCLES=16.
// Each frame is checked cycle by cycle against a small display model; the
// inputs for the following frame are changed mid-frame (sel=1).
module tb_sseg_scanner;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp = 4'h0;
   logic        blank_lz = 1'b0;
   logic [2:0]  brightness = 3'd0;
   logic [6:0]  sseg;
   logic        dp_n;
   logic [7:0]  AN;
   logic        frame_tick;

   int n_cmp  = 0;
   int n_fail = 0;

   sseg_scanner #(.DIGIT_CYCLES(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .digits     (digits),
      .dp         (dp),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .sseg       (sseg),
      .dp_n       (dp_n),
      .AN         (AN),
      .frame_tick (frame_tick)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   // Hand-written active-low hex patterns, bit order g..a.
   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'h0: seg_of = 7'h40;
         4'h1: seg_of = 7'h79;
         4'h2: seg_of = 7'h24;
         4'h3: seg_of = 7'h30;
         4'h4: seg_of = 7'h19;
         4'h5: seg_of = 7'h12;
         4'h6: seg_of = 7'h02;
         4'h7: seg_of = 7'h78;
         4'h8: seg_of = 7'h00;
         4'h9: seg_of = 7'h10;
         4'hA: seg_of = 7'h08;
         4'hB: seg_of = 7'h03;
         4'hC: seg_of = 7'h46;
         4'hD: seg_of = 7'h21;
         4'hE: seg_of = 7'h06;
         default: seg_of = 7'h0E;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [15:0] dg, input logic [3:0] dpv,
                        input logic blz, input logic [2:0] br);
      digits     = dg;
      dp         = dpv;
      blank_lz   = blz;
      brightness = br;
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, " AN"},   AN,               8'hFF);
      chk({tag, " sseg"}, {1'b0, sseg},     8'h7F);
      chk({tag, " dp_n"}, {7'b0, dp_n},     8'h01);
      chk({tag, " tick"}, {7'b0, frame_tick}, 8'h00);
   endtask

   // Walk one 64-cycle frame. Output after the j-th edge reflects slot
   // position j-1. The next frame's inputs are driven while sel=1.
   task automatic check_frame(input string name,
                              input logic [15:0] e_dg, input logic [3:0] e_dp,
                              input logic e_blz, input logic [2:0] e_br,
                              input logic [15:0] n_dg, input logic [3:0] n_dp,
                              input logic n_blz, input logic [2:0] n_br);
      for (int j = 1; j <= 64; j++) begin
         int s;
         int c;
         int ph;
         logic blank;
         logic lit;
         logic [7:0] e_an;
         logic [6:0] e_seg;
         logic e_dpn;
         step();
         s  = (j - 1) / 16;
         c  = (j - 1) % 16;
         ph = c / 2;
         blank = (s != 0) && e_blz && ((e_dg >> (4 * s)) == 16'h0000);
         lit   = !blank && (ph <= int'(e_br));
         e_an  = lit ? ~(8'h01 << s) : 8'hFF;
         e_seg = lit ? seg_of(e_dg[4*s +: 4]) : 7'h7F;
         e_dpn = lit ? ~e_dp[s] : 1'b1;
         chk($sformatf("%s AN j%0d", name, j),   AN,                e_an);
         chk($sformatf("%s sseg j%0d", name, j), {1'b0, sseg},      {1'b0, e_seg});
         chk($sformatf("%s dp_n j%0d", name, j), {7'b0, dp_n},      {7'b0, e_dpn});
         chk($sformatf("%s tick j%0d", name, j), {7'b0, frame_tick}, (j == 64) ? 8'h01 : 8'h00);
         if (j == 20) apply(n_dg, n_dp, n_blz, n_br);
      end
   endtask

   // Directed sequence.
   initial begin
      repeat (3) step();
      chk_dark("in_reset");
      reset_n = 1'b1;
      chk_dark("after_release");

      check_frame("f0_zero",  16'h0000, 4'h0, 1'b0, 3'd0, 16'h1234, 4'h0, 1'b0, 3'd7);
      check_frame("f1_1234",  16'h1234, 4'h0, 1'b0, 3'd7, 16'h0050, 4'h0, 1'b1, 3'd7);
      check_frame("f2_0050",  16'h0050, 4'h0, 1'b1, 3'd7, 16'h0000, 4'h0, 1'b1, 3'd7);
      check_frame("f3_0000",  16'h0000, 4'h0, 1'b1, 3'd7, 16'h1234, 4'h0, 1'b0, 3'd0);
      check_frame("f4_br0",   16'h1234, 4'h0, 1'b0, 3'd0, 16'h1234, 4'h0, 1'b0, 3'd3);
      check_frame("f5_br3",   16'h1234, 4'h0, 1'b0, 3'd3, 16'h1111, 4'h0, 1'b0, 3'd7);
      check_frame("f6_1111",  16'h1111, 4'h0, 1'b0, 3'd7, 16'h2222, 4'h0, 1'b0, 3'd7);
      check_frame("f7_2222",  16'h2222, 4'h0, 1'b0, 3'd7, 16'h0123, 4'b0100, 1'b1, 3'd7);
      check_frame("f8_dp",    16'h0123, 4'b0100, 1'b1, 3'd7, 16'h0003, 4'b0100, 1'b1, 3'd7);
      check_frame("f9_dpblk", 16'h0003, 4'b0100, 1'b1, 3'd7, 16'h5E8F, 4'b1010, 1'b0, 3'd5);
      check_frame("f10_hex",  16'h5E8F, 4'b1010, 1'b0, 3'd5, 16'h5E8F, 4'b1010, 1'b0, 3'd5);

      // Into the digit-2 slot, then reset without a clock edge.
      repeat (37) step();
      chk("pre_reset AN", AN, 8'hFB);
      #2;
      reset_n = 1'b0;
      #1;
      chk_dark("async_reset");
      step();
      step();
      chk_dark("held_reset");
      reset_n = 1'b1;
      chk_dark("rerelease");
      check_frame("r0_zero", 16'h0000, 4'h0, 1'b0, 3'd0, 16'h9876, 4'b0001, 1'b0, 3'd7);
      check_frame("r1_9876", 16'h9876, 4'b0001, 1'b0, 3'd7, 16'h9876, 4'b0001, 1'b0, 3'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
